regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Write-back side of the 32x32b register file. Merges two result sources onto the
//  file's single write port (regWrite/wrReg/wrData):
//   - A: single-cycle ALU results, highest priority, no backpressure.
//   - B: long-latency results (mult/div, loads), valid/ready handshake, buffered in a FIFO.
//  Also provides a pending-write query that issue logic uses to avoid hazards.
// PARAMETERS
//  DEPTH        4   B-result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT 4   consecutive A wins with FIFO non-empty before stall_a asserts (>=1)
// PORTS
//  clk         in   1    clock, all state on rising edge
//  reset       in   1    asynchronous, active-high reset
//  a_valid     in   1    ALU result valid
//  a_reg       in   5    ALU destination register
//  a_data      in   32   ALU result
//  stall_a     out  1    A not consumed this cycle; upstream re-presents same A next cycle
//  b_valid     in   1    long-latency result valid
//  b_ready     out  1    FIFO can accept B this cycle
//  b_reg       in   5    B destination register
//  b_data      in   32   B result
//  q_reg       in   5    register being checked for pending write
//  q_pending   out  1    write to q_reg still in FIFO or output stage
//  fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy
//  regWrite    out  1    register-file write enable (registered)
//  wrReg       out  5    register-file write address (registered)
//  wrData      out  32   register-file write data (registered)
// BEHAVIOUR
//  Reset (async, immediate): FIFO pointers/count=0, starve_cnt=0, regWrite=0,
//   wrReg=0, wrData=0. While reset=1: b_ready=0, stall_a=0, q_pending=0.
//  b_ready = (fifo_count < DEPTH). Push on b_valid & b_ready.
//   A push with b_reg==0 is accepted and discarded (count unchanged).
//  Per-cycle select, in priority order:
//   1. stall_a=1 -> pop FIFO head (count>0 guaranteed); A ignored.
//   2. a_valid & a_reg!=0 -> A.
//   3. fifo_count>0 -> pop FIFO head.
//   4. none.
//  a_valid with a_reg==0 is consumed with no write, and does not win over the FIFO.
//  Output stage, 1-cycle latency: regWrite <= (source selected);
//   wrReg/wrData <= selected reg/data. With no source, regWrite<=0 and wrReg/wrData hold.
//  Same-cycle push and pop are allowed; count changes by push-pop.
//   A push into a full FIFO is impossible (b_ready=0), even when a pop occurs that cycle.
//  No bypass: a B result pushed in cycle N can pop at N+1 at the earliest,
//   so it reaches the register file no earlier than N+2.
//  Starvation counter (starve_cnt, width covers STARVE_LIMIT):
//   - Increments when A wins while count>0.
//   - Clears on any pop or when count==0.
//   - stall_a = (starve_cnt == STARVE_LIMIT), combinational from the counter.
//   - A stall cycle pops the FIFO, so the counter clears the next cycle.
//  q_pending = (q_reg!=0) & (any valid FIFO entry reg==q_reg | (regWrite & wrReg==q_reg)).
//   Combinational. Issue logic stalls on it to prevent RAW/WAW against buffered writes.
//  Ordering: FIFO drains strictly in order. Between A and B, only the rules above decide
//   ordering; WAW avoidance is upstream's responsibility via q_pending.
//  Pointers wrap modulo DEPTH. Full = count==DEPTH; empty = count==0.
// TESTING
//  1. a_valid=1, a_reg=5, a_data=32'hDEADBEEF -> next cycle regWrite=1, wrReg=5, wrData=DEADBEEF.
//  2. Same cycle: A r3=1 and B r7=2, then idle -> cycle+1 writes r3=1, cycle+2 writes r7=2.
//  3. a_reg=0 valid -> regWrite stays 0. b_reg=0 pushed -> b_ready=1, fifo_count unchanged.
//  4. Continuous A, push 4 B entries (DEPTH=4) -> b_ready=0 at count 4; after 4 A wins
//     stall_a=1 for 1 cycle, head B written, count 3, the held A written the next cycle.
//  5. FIFO holds r9 -> q_reg=9 gives q_pending=1, q_reg=10 gives 0, q_reg=0 gives 0;
//     after r9 is written and regWrite drops, q_reg=9 gives 0.
//  6. FIFO count=3, assert reset mid-stream -> regWrite=0 and fifo_count=0 immediately;
//     after release, the first write is the next A/B input; no stale entries drain.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Write-back arbiter for the 32x32b register file. Source A (single-cycle ALU
// results) has priority and no backpressure; source B (long-latency results)
// is buffered in an in-order FIFO behind a valid/ready handshake. A starvation
// counter forces a FIFO pop after STARVE_LIMIT consecutive A wins, and a
// combinational pending-write query lets issue logic avoid RAW/WAW hazards.

module regfile_wb_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       a_valid,
   input  logic [4:0]                 a_reg,
   input  logic [31:0]                a_data,
   output logic                       stall_a,
   input  logic                       b_valid,
   output logic                       b_ready,
   input  logic [4:0]                 b_reg,
   input  logic [31:0]                b_data,
   input  logic [4:0]                 q_reg,
   output logic                       q_pending,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       regWrite,
   output logic [4:0]                 wrReg,
   output logic [31:0]                wrData
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

   logic [4:0]    fifo_reg_r  [DEPTH];
   logic [31:0]   fifo_data_r [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic [SW-1:0] starve_r;

   logic          stall_s;
   logic          push_s;
   logic          pop_s;
   logic          a_win_s;
   logic          sel_valid_s;
   logic [4:0]    sel_reg_s;
   logic [31:0]   sel_data_s;
   logic [CW-1:0] count_next_s;
   logic [SW-1:0] starve_next_s;
   logic          hit_s;

   assign fifo_count = count_r;

   // Handshake, source selection and next-state for occupancy and starvation.
   always_comb begin
      stall_s       = (starve_r == STARVE_C);
      b_ready       = 1'b0;
      stall_a       = 1'b0;
      pop_s         = 1'b0;
      a_win_s       = 1'b0;
      sel_valid_s   = 1'b0;
      sel_reg_s     = wrReg;
      sel_data_s    = wrData;
      count_next_s  = count_r;
      starve_next_s = starve_r;

      if (reset) begin
         b_ready = 1'b0;
         stall_a = 1'b0;
      end else begin
         b_ready = (count_r < DEPTH_C);
         stall_a = stall_s;
      end

      // Register 0 results are accepted but never stored.
      push_s = b_valid & b_ready & (b_reg != 5'd0);

      if (stall_s) begin
         pop_s       = 1'b1;
         sel_valid_s = 1'b1;
         sel_reg_s   = fifo_reg_r[rd_ptr_r];
         sel_data_s  = fifo_data_r[rd_ptr_r];
      end else if (a_valid && (a_reg != 5'd0)) begin
         a_win_s     = 1'b1;
         sel_valid_s = 1'b1;
         sel_reg_s   = a_reg;
         sel_data_s  = a_data;
      end else if (count_r != {CW{1'b0}}) begin
         pop_s       = 1'b1;
         sel_valid_s = 1'b1;
         sel_reg_s   = fifo_reg_r[rd_ptr_r];
         sel_data_s  = fifo_data_r[rd_ptr_r];
      end else begin
         sel_valid_s = 1'b0;
      end

      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase

      // A stall always pops, so the counter never runs past the limit.
      if (pop_s || (count_r == {CW{1'b0}})) begin
         starve_next_s = {SW{1'b0}};
      end else if (a_win_s) begin
         starve_next_s = starve_r + SW'(1);
      end else begin
         starve_next_s = starve_r;
      end
   end

   // Pending-write query over live FIFO entries and the output stage.
   always_comb begin
      hit_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_s = hit_s | ((CW'(i) < count_r) &
                          (fifo_reg_r[rd_ptr_r + AW'(i)] == q_reg));
      end
      hit_s = hit_s | (regWrite & (wrReg == q_reg));
      if (reset) begin
         q_pending = 1'b0;
      end else begin
         q_pending = hit_s & (q_reg != 5'd0);
      end
   end

   // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_reg_r[i]  <= 5'd0;
            fifo_data_r[i] <= 32'd0;
         end
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         starve_r <= {SW{1'b0}};
      end else begin
         if (push_s) begin
            fifo_reg_r[wr_ptr_r]  <= b_reg;
            fifo_data_r[wr_ptr_r] <= b_data;
            wr_ptr_r              <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r  <= count_next_s;
         starve_r <= starve_next_s;
      end
   end

   // Registered register-file write port; address/data hold when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regWrite <= 1'b0;
         wrReg    <= 5'd0;
         wrData   <= 32'd0;
      end else if (sel_valid_s) begin
         regWrite <= 1'b1;
         wrReg    <= sel_reg_s;
         wrData   <= sel_data_s;
      end else begin
         regWrite <= 1'b0;
      end
   end

endmodule
